fir_mac_sequencer: RTL and testbench



---
 rtl/fir_mac_sequencer.sv | 132 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed 8-tap FIR multiply-accumulate sequencer
// Purpose: accepts one sample per handshake, walks the coefficient ROM over TAPS
//    cycles against an internal delay line, rounds/saturates, returns one sample.
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   input sample handshake, in_sample signed DATA_W
//    coef_addr/coef_rd   tap index to coefficient ROM, coef_data returned same cycle
//    out_valid/out_ready output sample handshake, out_sample signed DATA_W
//    busy                high whenever not idle
module fir_mac_sequencer #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 21,
   parameter int COEF_FRAC = 20,
   parameter int TAPS      = 8,
   parameter int ACC_W     = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_sample,
   output logic [2:0]               coef_addr,
   output logic                     coef_rd,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_sample,
   output logic                     busy
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [2:0]              LAST_TAP = 3'(TAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic signed [DATA_W-1:0]  x [TAPS];
   logic signed [ACC_W-1:0]   acc;
   logic [2:0]                tap;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_rnd;
   logic signed [ACC_W-1:0]   r;
   logic signed [DATA_W-1:0]  sat_val;

   // Full-width signed product, sign-extended into the accumulator's guard bits.
   assign prod     = x[tap] * coef_data;
   assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

   // Round half up then arithmetic shift; clamp only here, never in acc.
   assign acc_rnd = acc + HALF;
   assign r       = acc_rnd >>> COEF_FRAC;

   always_comb begin
      sat_val = r[DATA_W-1:0];
      if (r > SAT_MAX)
         sat_val = SAT_MAX[DATA_W-1:0];
      else if (r < SAT_MIN)
         sat_val = SAT_MIN[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      coef_rd   = 1'b0;
      coef_addr = 3'd0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid)
               state_nxt = MAC;
         end
         MAC: begin
            coef_rd   = 1'b1;
            coef_addr = tap;
            if (tap == LAST_TAP)
               state_nxt = ROUND;
         end
         ROUND: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++)
            x[k] <= '0;
         acc        <= '0;
         tap        <= 3'd0;
         out_sample <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int k = TAPS - 1; k > 0; k--)
                     x[k] <= x[k-1];
                  x[0] <= in_sample;
                  acc  <= '0;
                  tap  <= 3'd0;
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               if (tap != LAST_TAP)
                  tap <= tap + 3'd1;
            end
            ROUND: out_sample <= sat_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_sample;
   logic [2:0]         coef_addr;
   logic               coef_rd;
   logic signed [20:0] coef_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_sample;
   logic               busy;

   logic signed [20:0] coef_rom [8];
   int                 hist [8];
   int                 errors = 0;
   int                 checks = 0;

   always #5 clk = ~clk;

   assign coef_data = coef_rom[coef_addr];

   fir_mac_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sample  (in_sample),
      .coef_addr  (coef_addr),
      .coef_rd    (coef_rd),
      .coef_data  (coef_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sample (out_sample),
      .busy       (busy)
   );

   function automatic void model_clear();
      for (int k = 0; k < 8; k++) hist[k] = 0;
   endfunction

   function automatic void model_push(input logic signed [15:0] s);
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(s);
   endfunction

   // y = sum(x[k]*h[k]) / 2^20, rounded half up, clamped to 16-bit signed.
   function automatic logic [15:0] model_result();
      longint sum = 0;
      longint q;
      for (int k = 0; k < 8; k++)
         sum += longint'(hist[k]) * longint'(coef_rom[k]);
      q = (sum + 524288) / 1048576;
      if ((sum + 524288) % 1048576 != 0 && (sum + 524288) < 0) q = q - 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   function automatic void set_coefs(input logic signed [20:0] h0, input logic signed [20:0] rest);
      coef_rom[0] = h0;
      for (int k = 1; k < 8; k++) coef_rom[k] = rest;
   endfunction

   task automatic send(input logic signed [15:0] s, input int stall, output logic [15:0] res);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      in_valid = 1'b1;
      in_sample = s;
      @(negedge clk);
      in_valid = 1'b0;
      in_sample = 16'($urandom);
      model_push(s);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout: out_valid=%b required 1", out_valid);
      end
      repeat (stall) @(negedge clk);
      res = out_sample;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sample = '0;
      set_coefs(21'sd0, 21'sd0);
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, out_valid, coef_rd, coef_addr, out_sample} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b busy=%b ov=%b rd=%b addr=%0d out=%h required 1 0 0 0 0 0000",
                  in_ready, busy, out_valid, coef_rd, coef_addr, out_sample);
      end
   endtask

   task automatic test_impulse();
      logic [15:0] res;
      logic [15:0] s;
      set_coefs(21'sh0B0000, 21'sd0);
      for (int i = 0; i < 8; i++) begin
         s = (i == 0) ? 16'h4000 : 16'h0000;
         send(s, 0, res);
         checks++;
         if (res !== ((i == 0) ? 16'h2C00 : 16'h0000)) begin
            errors++;
            $display("FAIL impulse_h0[%0d]: got %h required %h", i, res, (i == 0) ? 16'h2C00 : 16'h0000);
         end
      end
      for (int k = 0; k < 8; k++) coef_rom[k] = (k == 3) ? 21'sh0B0000 : 21'sd0;
      for (int i = 0; i < 8; i++) begin
         s = (i == 0) ? 16'h4000 : 16'h0000;
         send(s, 0, res);
         checks++;
         if (res !== ((i == 3) ? 16'h2C00 : 16'h0000)) begin
            errors++;
            $display("FAIL impulse_h3[%0d]: got %h required %h", i, res, (i == 3) ? 16'h2C00 : 16'h0000);
         end
      end
   endtask

   task automatic test_addr_seq();
      logic signed [15:0] s;
      logic [15:0] exp;
      for (int k = 0; k < 8; k++) coef_rom[k] = 21'($urandom);
      s = 16'($urandom);
      in_valid = 1'b1; in_sample = s;
      @(negedge clk);
      in_valid = 1'b0;
      model_push(s);
      exp = model_result();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({coef_rd, coef_addr, in_ready, busy} !== {1'b1, 3'(i), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL addr_seq[%0d]: rd=%b addr=%0d rdy=%b busy=%b required 1 %0d 0 1",
                     i, coef_rd, coef_addr, in_ready, busy, i);
         end
         @(negedge clk);
      end
      checks++;
      if ({out_valid, coef_rd, in_ready} !== 3'b000) begin
         errors++;
         $display("FAIL round_cycle: ov=%b rd=%b rdy=%b required 000", out_valid, coef_rd, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sample !== exp || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL latency_out: ov=%b out=%h rdy=%b required 1 %h 0", out_valid, out_sample, in_ready, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sample !== exp) begin
         errors++;
         $display("FAIL post_handshake: ov=%b rdy=%b out=%h required 0 1 %h", out_valid, in_ready, out_sample, exp);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] res;
      set_coefs(21'sh0FFFFF, 21'sh0FFFFF);
      for (int i = 0; i < 8; i++) send(16'sh7FFF, 0, res);
      checks++;
      if (res !== 16'h7FFF) begin
         errors++;
         $display("FAIL sat_pos: got %h required 7fff", res);
      end
      for (int i = 0; i < 8; i++) send(16'sh8000, 0, res);
      checks++;
      if (res !== 16'h8000) begin
         errors++;
         $display("FAIL sat_neg: got %h required 8000", res);
      end
   endtask

   task automatic test_backpressure();
      logic signed [15:0] s;
      logic [15:0] exp;
      logic [15:0] res;
      int n;
      for (int k = 0; k < 8; k++) coef_rom[k] = 21'($urandom);
      s = 16'($urandom);
      in_valid = 1'b1; in_sample = s;
      @(negedge clk);
      in_valid = 1'b0;
      model_push(s);
      exp = model_result();
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_sample !== exp || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: ov=%b out=%h rdy=%b required 1 %h 0",
                     i, out_valid, out_sample, in_ready, exp);
         end
         in_valid = 1'b1;
         in_sample = 16'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: ov=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         s = 16'($urandom);
         send(s, 0, res);
         exp = model_result();
         checks++;
         if (res !== exp) begin
            errors++;
            $display("FAIL backpressure_follow[%0d]: got %h required %h", i, res, exp);
         end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [15:0] res;
      bit seen;
      in_valid = 1'b1; in_sample = 16'sh1234;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, out_valid, coef_rd, coef_addr, out_sample} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0}) begin
         errors++;
         $display("FAIL reset_mid_mac: rdy=%b busy=%b ov=%b rd=%b addr=%0d out=%h required 1 0 0 0 0 0000",
                  in_ready, busy, out_valid, coef_rd, coef_addr, out_sample);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_output: out_valid seen=%b required 0", seen);
      end
      set_coefs(21'sh0B0000, 21'sd0);
      coef_rom[1] = 21'sh0B0000;
      send(16'sh4000, 0, res);
      checks++;
      if (res !== 16'h2C00) begin
         errors++;
         $display("FAIL reset_cleared_line: got %h required 2c00", res);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] res;
      set_coefs(21'sd1, 21'sd0);
      send(16'sh7FFF, 0, res);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL round_pos: got %h required 0000", res); end
      send(16'sh8000, 0, res);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL round_neg: got %h required 0000", res); end
      coef_rom[0] = 21'sh080000;
      send(-16'sd1, 0, res);
      checks++;
      if (res !== 16'h0000) begin errors++; $display("FAIL round_half_neg: got %h required 0000", res); end
      send(16'sd1, 0, res);
      checks++;
      if (res !== 16'h0001) begin errors++; $display("FAIL round_half_pos: got %h required 0001", res); end
   endtask

   task automatic test_random();
      logic [15:0] res;
      logic [15:0] exp;
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 8; k++) coef_rom[k] = 21'($urandom);
         send(16'($urandom), int'($urandom_range(0, 3)), res);
         exp = model_result();
         checks++;
         if (res !== exp) begin
            errors++;
            $display("FAIL random[%0d]: got %h required %h", i, res, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_addr_seq();
      test_saturation();
      test_backpressure();
      test_reset_mid_mac();
      test_rounding();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
